mat_vec_mult: RTL and testbench
===============================

// Module: mat_vec_mult
// PURPOSE
//  - 8x8 matrix-times-vector engine: out[i] = sum_j A[i][j]*B[j], i,j = 0..7.
//  - Eight row FIFOs buffer matrix A (one row per FIFO); one FIFO buffers vector B.
//  - Eight parallel MAC units consume the FIFOs once all are full.
//  - Leaf compute block fed by a host or loader; results held in accumulators until cleared.
// PARAMETERS
//  - DEPTH       8  entries per FIFO; equals matrix/vector dimension. Only 8 supported.
//  - DATA_WIDTH  8  operand width; each out[i] is 3*DATA_WIDTH bits.
// PORTS
//  - clk        in   1                 single clock, all logic on posedge
//  - rst_n      in   1                 async active-low reset
//  - Clr        in   1                 sync active-low clear
//  - a_wren     in   1                 push a_fifo_in[i] into A FIFO i, all i together
//  - b_wren     in   1                 push b_fifo_in into B FIFO
//  - a_fifo_in  in   [DW-1:0] x[7:0]   unpacked array; element i = next A[i][j]
//  - b_fifo_in  in   DW                next B[j]
//  - out        out  [3*DW-1:0] x[7:0] per-row accumulator
// BEHAVIOUR
//  - Reset (rst_n=0, async): all FIFOs empty, FSM=IDLE, every out[i]=0.
//  - Clr=0 at a posedge: same effect as reset, synchronously. Overrides writes and RUN.
//  - FIFOs: synchronous write/read, 8 entries, wrap-around pointers with full/empty flags.
//    - A write to a full FIFO is dropped; its contents are unchanged.
//    - Each A FIFO FIFO fills in the same cycle because a_wren is shared.
//  - FSM states: IDLE, RUN (3-bit count 0..7).
//    - IDLE->RUN when all A FIFOs and the B FIFO are full at edge T.
//    - RUN: rden is high to all 9 FIFOs for 8 cycles (T..T+7); entries pop at edges T+1..T+8.
//    - RUN->IDLE after count=7.
//    - A partial load, e.g. A full but B holding 1 entry, never starts RUN; out is unchanged.
//  - Datapath:
//    - FIFO read data is registered.
//    - MAC i computes acc_i += A_i*B on the edge after each pop, i.e. edges T+2..T+9.
//    - The final result is valid from edge T+9 until the next Clr or RUN.
//  - Arithmetic: unsigned by default.
//    - Product is 2*DW bits, zero-extended into a 3*DW accumulator.
//    - Max 8*255*255=520200 fits in 24 bits; the accumulator wraps modulo 2^(3*DW).
//  - Successive batches accumulate on top of the prior result unless Clr is pulsed.
//  - Writes during RUN are accepted if the FIFO is not full.
//  - Simultaneous read and write on one FIFO is legal; count is unchanged.
//  - rst_n asserted mid-RUN aborts immediately: all state returns to reset values.
// CONFIGURATION
//  - MAT_VEC_SIGNED_EN defined:
//    - Operands are two's complement.
//    - Products are sign-extended to 3*DW before accumulation.
//  - MAT_VEC_SIGNED_EN undefined: unsigned operands, zero extension.
// TESTING
//  - Reset/Clr: drive Clr=0 for 1 cycle mid-accumulation -> all out=0 next edge, FIFOs empty.
//  - All-ones, unsigned build:
//    - 8 a_wren cycles with every element = 1, then 8 b_wren cycles with B = 1.
//    - Required: every out[i]=8 at T+9.
//  - Max values: A and B all 255 -> every out[i]=520200 (0x07F008).
//  - Row-distinct data:
//    - A[i][j]=i+1, B[j]=j.
//    - Required: out[i]=(i+1)*28, i.e. 28, 56, ..., 224.
//    - Second batch without Clr -> values double.
//  - Partial load: A filled, single B write of 1 -> no RUN, out stays 0 for 20 cycles.
//  - Signed build: A all 0xFF (-1), B all 2 -> every out[i]=0xFFFFF0 (-16).

Source files
------------

// File: rtl/mat_vec_mult.sv
// mat_vec_mult: 8x8 matrix-times-vector engine.
// Eight row FIFOs hold A, one FIFO holds B. When all nine are full, the FSM
// reads them for 8 cycles. Each row MAC accumulates A[i][j]*B[j] into out[i].
// Optional macro MAT_VEC_SIGNED_EN selects two's-complement operands with
// sign-extended products. The default build uses unsigned operands.

module mvm_fifo #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_n,
    input  logic                  wren,
    input  logic                  rden,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wptr, rptr;
    logic [CW-1:0]         count;
    logic                  wr_ok, rd_ok;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    // A write to a full FIFO is dropped, even when a read happens in the same cycle.
    assign wr_ok = clr_n && wren && !full;
    assign rd_ok = clr_n && rden && !empty;

    // Storage array; stale contents are harmless because the pointers are reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr] <= din;
    end

    // Pointers, occupancy count and the registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            dout  <= '0;
        end else if (!clr_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            dout  <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
                dout <= mem[rptr];
            end
            count <= count + CW'(wr_ok) - CW'(rd_ok);
        end
    end
endmodule

module mvm_mac #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_n,
    input  logic                    en,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic [3*DATA_WIDTH-1:0] acc
);
    localparam int DW = DATA_WIDTH;

    logic [3*DW-1:0] prod_ext;
`ifdef MAT_VEC_SIGNED_EN
    logic signed [2*DW-1:0] prod;
    assign prod     = $signed(a) * $signed(b);
    assign prod_ext = {{DW{prod[2*DW-1]}}, prod};
`else
    logic [2*DW-1:0] prod;
    assign prod     = a * b;
    assign prod_ext = {{DW{1'b0}}, prod};
`endif

    // Accumulate one product per valid read. The sum wraps modulo 2^(3*DW).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      acc <= '0;
        else if (!clr_n) acc <= '0;
        else if (en)     acc <= acc + prod_ext;
    end
endmodule

module mat_vec_mult #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    Clr,
    input  logic                    a_wren,
    input  logic                    b_wren,
    input  logic [DATA_WIDTH-1:0]   a_fifo_in [DEPTH],
    input  logic [DATA_WIDTH-1:0]   b_fifo_in,
    output logic [3*DATA_WIDTH-1:0] out       [DEPTH]
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t                state, state_nxt;
    logic [2:0]            cnt, cnt_nxt;
    logic                  rden;
    logic                  rd_vld;
    logic [DEPTH-1:0]      a_full;
    logic [DEPTH-1:0]      a_empty;
    logic                  b_full, b_empty;
    logic [DATA_WIDTH-1:0] a_dout [DEPTH];
    logic [DATA_WIDTH-1:0] b_dout;

    assign rden = (state == RUN);

    mvm_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_b_fifo (
        .clk(clk), .rst_n(rst_n), .clr_n(Clr), .wren(b_wren), .rden(rden),
        .din(b_fifo_in), .dout(b_dout), .full(b_full), .empty(b_empty)
    );

    for (genvar i = 0; i < DEPTH; i++) begin : g_row
        mvm_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_a_fifo (
            .clk(clk), .rst_n(rst_n), .clr_n(Clr), .wren(a_wren), .rden(rden),
            .din(a_fifo_in[i]), .dout(a_dout[i]), .full(a_full[i]), .empty(a_empty[i])
        );
        mvm_mac #(.DATA_WIDTH(DATA_WIDTH)) u_mac (
            .clk(clk), .rst_n(rst_n), .clr_n(Clr), .en(rd_vld),
            .a(a_dout[i]), .b(b_dout), .acc(out[i])
        );
    end

    // The empty flags are not needed: RUN starts only from a completely full load.
    logic unused_empty;
    assign unused_empty = ^{a_empty, b_empty};

    // The FIFO read data is registered, so the MAC runs one cycle behind rden.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    rd_vld <= 1'b0;
        else if (!Clr) rd_vld <= 1'b0;
        else           rd_vld <= rden;
    end

    // State register. Clr drops any batch that is in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (!Clr) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: start when every FIFO is full, then read 8 entries.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (&a_full && b_full) begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
            RUN: if (cnt == 3'd7) state_nxt = IDLE;
                 else             cnt_nxt   = cnt + 3'd1;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mat_vec_mult.sv
// Scoreboard bench for mat_vec_mult.
// The stimulus pushes {check cycle, expected outs} into a queue. A monitor
// compares the outputs on the falling edge of the tagged cycle.
module tb_mat_vec_mult;
    logic        clk = 1'b0;
    logic        rst_n, Clr, a_wren, b_wren;
    logic [7:0]  a_fifo_in [8];
    logic [7:0]  b_fifo_in;
    logic [23:0] out [8];

    mat_vec_mult #(.DEPTH(8), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .Clr(Clr), .a_wren(a_wren), .b_wren(b_wren),
        .a_fifo_in(a_fifo_in), .b_fifo_in(b_fifo_in), .out(out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              tag;
        int              id;
        logic [7:0][23:0] exp;
    } chk_t;
    chk_t q[$];

    int n_chk = 0, n_fail = 0, chk_id = 0;

    logic [7:0]  A [8][8];
    logic [7:0]  B [8];
    logic [23:0] acc_m [8];

    function automatic logic [23:0] pm(input logic [7:0] a, input logic [7:0] b);
`ifdef MAT_VEC_SIGNED_EN
        logic signed [7:0]  sa, sb;
        logic signed [23:0] p;
        sa = a; sb = b;
        p  = sa * sb;
        return p;
`else
        return {16'b0, a} * {16'b0, b};
`endif
    endfunction

    task automatic push(input int tag, input logic [7:0][23:0] e);
        chk_t c;
        c.tag = tag; c.id = chk_id; c.exp = e;
        chk_id++;
        q.push_back(c);
    endtask

    task automatic push_model(input int tag);
        logic [7:0][23:0] e;
        for (int i = 0; i < 8; i++) e[i] = acc_m[i];
        push(tag, e);
    endtask

    // Monitor: on the tagged falling edge, compare all eight rows.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].tag < cyc) begin
            n_chk++; n_fail++;
            $display("FAIL chk%0d missed: tag %0d now %0d", q[0].id, q[0].tag, cyc);
            void'(q.pop_front());
        end else if (q.size() > 0 && q[0].tag == cyc) begin
            chk_t c;
            c = q.pop_front();
            for (int r = 0; r < 8; r++) begin
                n_chk++;
                if (out[r] !== c.exp[r]) begin
                    n_fail++;
                    $display("FAIL chk%0d row%0d cyc%0d: got %h want %h",
                             c.id, r, cyc, out[r], c.exp[r]);
                end
            end
        end
    end

    // Write na columns of A, then nb entries of B. A column index of 8 or
    // more writes 100, which must be dropped by the full FIFOs.
    task automatic load(input int na, input int nb, output int ce);
        for (int j = 0; j < na; j++) begin
            @(posedge clk); #1;
            a_wren = 1'b1;
            for (int i = 0; i < 8; i++) a_fifo_in[i] = (j < 8) ? A[i][j] : 8'd100;
        end
        for (int j = 0; j < nb; j++) begin
            @(posedge clk); #1;
            a_wren = 1'b0; b_wren = 1'b1; b_fifo_in = B[j];
        end
        @(posedge clk); #1;
        a_wren = 1'b0; b_wren = 1'b0;
        ce = cyc;
    endtask

    // Full batch: one cycle before completion, the last product is still missing.
    task automatic run_batch(input int na);
        int ce;
        logic [7:0][23:0] pre;
        load(na, 8, ce);
        for (int i = 0; i < 8; i++) begin
            logic [23:0] s;
            s = acc_m[i];
            for (int j = 0; j < 7; j++) s = s + pm(A[i][j], B[j]);
            pre[i]   = s;
            acc_m[i] = s + pm(A[i][7], B[7]);
        end
        push(ce + 9, pre);
        push_model(ce + 10);
        push_model(ce + 14);
        repeat (15) @(posedge clk);
        #1;
    endtask

    task automatic clr_pulse();
        @(posedge clk); #1 Clr = 1'b0;
        @(posedge clk); #1 Clr = 1'b1;
        for (int i = 0; i < 8; i++) acc_m[i] = '0;
        push_model(cyc);
        @(posedge clk); #1;
    endtask

    task automatic set_ab(input int mode);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                case (mode)
                    0: A[i][j] = 8'd1;
                    1: A[i][j] = 8'd255;
                    2: A[i][j] = 8'(i + 1);
                    default: A[i][j] = 8'hFF;
                endcase
            end
            case (mode)
                0: B[i] = 8'd1;
                1: B[i] = 8'd255;
                2: B[i] = 8'(i);
                default: B[i] = 8'd2;
            endcase
        end
    endtask

    initial begin
        int ce;
        logic [7:0][23:0] e;
        rst_n = 1'b0; Clr = 1'b1; a_wren = 1'b0; b_wren = 1'b0; b_fifo_in = '0;
        for (int i = 0; i < 8; i++) begin
            a_fifo_in[i] = '0;
            acc_m[i]     = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        push_model(cyc + 1);

`ifdef MAT_VEC_SIGNED_EN
        set_ab(3); run_batch(8);
        for (int i = 0; i < 8; i++) e[i] = 24'hFFFFF0;
        push(cyc + 1, e);
        @(posedge clk); #1;
`else
        // All ones: every row must end at 8.
        set_ab(0); run_batch(8);
        for (int i = 0; i < 8; i++) e[i] = 24'd8;
        push(cyc + 1, e);
        @(posedge clk); #1;
        clr_pulse();

        // Maximum operands: every row must end at 520200.
        set_ab(1); run_batch(8);
        for (int i = 0; i < 8; i++) e[i] = 24'h07F008;
        push(cyc + 1, e);
        @(posedge clk); #1;
        clr_pulse();

        // Row-distinct data, then a second batch that doubles the result.
        set_ab(2); run_batch(8);
        for (int i = 0; i < 8; i++) e[i] = 24'((i + 1) * 28);
        push(cyc + 1, e);
        @(posedge clk); #1;
        run_batch(8);
        for (int i = 0; i < 8; i++) e[i] = 24'((i + 1) * 56);
        push(cyc + 1, e);
        @(posedge clk); #1;
`endif

        // Clr in the middle of accumulation: outputs zero on the next edge and stay zero.
        load(8, 8, ce);
        while (cyc < ce + 5) begin
            @(posedge clk); #1;
        end
        Clr = 1'b0;
        @(posedge clk); #1;
        Clr = 1'b1;
        for (int i = 0; i < 8; i++) acc_m[i] = '0;
        push_model(cyc);
        push_model(cyc + 8);
        repeat (10) @(posedge clk);
        #1;

        // Partial load: A full, one B entry. RUN must not start.
        set_ab(0);
        load(8, 1, ce);
        push_model(ce + 10);
        push_model(ce + 20);
        repeat (21) @(posedge clk);
        #1;
        clr_pulse();

        // A ninth A write hits full FIFOs and must be dropped: out[i] = 8*(i+1).
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) A[i][j] = 8'(i + 1);
            B[i] = 8'd1;
        end
        run_batch(9);
        for (int i = 0; i < 8; i++) e[i] = 24'((i + 1) * 8);
        push(cyc + 1, e);
        @(posedge clk); #1;

        for (int k = 0; k < 50 && q.size() > 0; k++) @(posedge clk);
        if (q.size() > 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain: %0d checks pending, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
